// File: rtl/pe_act_queue.sv
`default_nettype none
// ============================================================================
// Module   : pe_act_queue
// Purpose  : Per-PE first-word-fall-through activation queue with credit pops.
//            Optional same-cycle empty-queue bypass: PE_ACT_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 8
`endif

`ifndef PEQueueBus
`define PEQueueBus [19:0]
`endif

module pe_act_queue #(
    parameter int PE_IDX = 0,
    parameter int DEPTH  = `ROUTER_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_act,
    input  logic `PEQueueBus act_in,
    output logic             act_valid,
    output logic `PEQueueBus act_out,
    input  logic             act_ready,
    output logic             pop_act,
    output logic [CNT_W-1:0] queue_count,
    output logic             overflow_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic `PEQueueBus r_mem [DEPTH];
    logic [CNT_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_rptr;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_pop_mem;
    logic w_push_acc;
    logic w_overflow_evt;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                     (r_wptr[CNT_W-1] != r_rptr[CNT_W-1]);

`ifdef PE_ACT_QUEUE_BYPASS_EN
    // rst_n gating keeps every output at zero while reset is held
    assign w_bypass = w_empty & push_act & rst_n;
`else
    assign w_bypass = 1'b0;
`endif

    assign act_valid = ~w_empty | w_bypass;
    assign act_out   = !w_empty ? r_mem[r_rptr[ADDR_W-1:0]] :
                       (w_bypass ? act_in : '0);
    assign pop_act   = act_valid & act_ready;

    // A bypassed pop never touched storage, so only non-empty pops move rptr
    assign w_pop_mem      = pop_act & ~w_empty;
    assign w_push_acc     = push_act & (~w_full | w_pop_mem) & ~(w_bypass & act_ready);
    assign w_overflow_evt = push_act & w_full & ~w_pop_mem;

    assign queue_count  = r_wptr - r_rptr;
    assign overflow_err = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + CNT_W'(1);
            end
            if (w_pop_mem) begin
                r_rptr <= r_rptr + CNT_W'(1);
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: empty gating hides stale contents
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= act_in;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && w_overflow_evt) begin
            $display("pe_act_queue[%0d]: overflow, dropped entry %h at %0t", PE_IDX, act_in, $time);
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/pe_act_queue.md
# pe_act_queue

Per-PE activation queue sitting directly downstream of the PE network interface. It buffers broadcast activations pushed by the network interface, presents them in FIFO order to the PE datapath over a valid/ready handshake, and emits one `pop_act` pulse per dequeued entry. The network interface turns each pulse into a credit returned to the leaf router. Depth matches the router FIFO depth, so credit flow control guarantees no overflow in correct operation.

## Interface
- `PE_IDX`, default 0: PE index, used only in simulation messages.
- `DEPTH`, default `` `ROUTER_FIFO_DEPTH ``: number of entries. Must be a power of two and at least 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `push_act`  in  1  enqueue strobe from the network interface.
- `act_in`  in  `` `PEQueueBus ``  activation entry, `{pe_addr, data}`.
- `act_valid`  out  1  head entry is valid.
- `act_out`  out  `` `PEQueueBus ``  head entry.
- `act_ready`  in  1  datapath accepts the head this cycle.
- `pop_act`  out  1  dequeue pulse, wired to the network interface.
- `queue_count`  out  `CNT_W`  current occupancy.
- `overflow_err`  out  1  sticky error: a push arrived while the queue was full.

## Operation
- Storage is a circular buffer of `DEPTH` entries with write and read pointers. Each pointer is `CNT_W` bits: the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- The queue is first-word fall-through. `act_out` is the entry at the read pointer. `act_valid` = !empty.
- Dequeue: `pop_act` = `act_valid & act_ready`, combinational. It advances the read pointer on the clock edge.
- Enqueue: on `push_act` with the queue not full, write `act_in` at the write pointer and advance the write pointer.
- Push while full:
  - With no simultaneous pop, the entry is dropped and `overflow_err` is set to 1 until reset.
  - With a simultaneous pop, the push is accepted. Occupancy stays `DEPTH`.
- Push while empty, bypass compiled out: the entry is stored. `act_valid` rises next cycle.
- Occupancy update:
  - `queue_count` increments on an accepted push only.
  - It decrements on a pop only.
  - It is unchanged on both or neither.
- Pointers wrap modulo `2*DEPTH`. No other saturation logic exists.
- `act_out` must hold stable while `act_valid & !act_ready`. The datapath may stall indefinitely.
- Simulation only: `$display` of `PE_IDX`, entry and time on overflow.

## Timing
- Reset (async assert, sync release):
  - pointers = 0, `queue_count` = 0, `overflow_err` = 0.
  - `act_valid` = 0, `pop_act` = 0, `act_out` = 0.
  - Memory contents are don't-care, but `act_out` is gated to 0 when empty.
- Push at edge t makes `act_valid` high from cycle t+1 (bypass off).
- `pop_act` is high in the same cycle as the `act_valid & act_ready` handshake. The network interface registers it, so the credit reaches the router one cycle later.
- Sustained throughput is one push and one pop per cycle.
- Reset asserted mid-stream discards all entries immediately. No `pop_act` pulses are generated for discarded entries.

## Configuration
- `PE_ACT_QUEUE_BYPASS_EN` defined:
  - When the queue is empty and `push_act` is high, `act_valid` = 1 and `act_out` = `act_in` in the same cycle.
  - If `act_ready` is also high, `pop_act` = 1 and the entry is not stored. Pointers and count are unchanged.
  - If `act_ready` is low, the entry is stored as normal.
- Not defined:
  - No combinational path from `push_act`/`act_in` to `act_valid`/`act_out`/`pop_act`.
  - Minimum push-to-pop latency is 1 cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-operation with `queue_count`=3 -> all outputs 0 asynchronously. After release, `act_valid`=0 and `queue_count`=0.
- Ordering: push 0x1_0005, 0x2_0006, 0x3_0007 with `act_ready`=0, then `act_ready`=1 -> `act_out` yields the entries in push order on consecutive cycles, with 3 `pop_act` pulses and `queue_count` 3→2→1→0.
- Full: `DEPTH`=8, 9 pushes with `act_ready`=0 -> `queue_count`=8, the 9th entry is absent from the drained stream, and `overflow_err`=1 stays set after draining.
- Full with simultaneous push/pop: 8 entries stored, push 0xAAAA with `act_ready`=1 in the same cycle -> no overflow, `queue_count` stays 8, 0xAAAA is popped last.
- Wrap-around: stream 20 pushes with `act_ready` toggling 1-of-2 cycles -> all 20 entries received in order, no overflow, final `queue_count`=0.
- Bypass: with `PE_ACT_QUEUE_BYPASS_EN`, empty queue, push 0x4_0010 with `act_ready`=1 -> `act_valid`/`pop_act`=1 and `act_out`=0x4_0010 in the same cycle, `queue_count` stays 0. Without the macro -> pop occurs at t+1 and `queue_count` pulses to 1.
